// File: rtl/prewish_mentor_if.sv
// Student-port bus between a prewish mentor (master) and its blinky students (slave).
// With MENTOR_ACK_EN defined the bus also carries the ACK_I return handshake.
interface prewish_mentor_if;
    logic       STB_O;
    logic [7:0] DAT_O;
`ifdef MENTOR_ACK_EN
    logic       ACK_I;

    modport master (output STB_O, output DAT_O, input  ACK_I);
    modport slave  (input  STB_O, input  DAT_O, output ACK_I);
`else
    modport master (output STB_O, output DAT_O);
    modport slave  (input  STB_O, input  DAT_O);
`endif
endinterface

// File: rtl/prewish_mentor.sv
// prewish_mentor: steps a small writable mask table into prewish students over STB_O/DAT_O.
// Optional MENTOR_ACK_EN: strobe ends on ACK_I or after ACK_TIMEOUT clocks (sticky err_o).
module prewish_mentor #(
    parameter int unsigned IDX_BITS    = 2,
    parameter int unsigned STB_CYCLES  = 1,
    parameter int unsigned HOLD_CYCLES = 24000000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [IDX_BITS-1:0] last_i,
    input  logic                tbl_we_i,
    input  logic [IDX_BITS-1:0] tbl_addr_i,
    input  logic [7:0]          tbl_dat_i,
    prewish_mentor_if.master    bus,
    output logic                busy_o,
`ifdef MENTOR_ACK_EN
    output logic                err_o,
`endif
    output logic                wrap_o
);

`ifdef MENTOR_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    localparam int unsigned DEPTH     = 1 << IDX_BITS;
    localparam int unsigned STB_LIM   = ACK_EN ? ACK_TIMEOUT : STB_CYCLES;
    localparam int unsigned SW        = (STB_LIM > 1) ? $clog2(STB_LIM) : 1;
    localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] STB_LAST  = SW'(STB_LIM - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [SW-1:0]       stb_cnt_q, stb_cnt_d;
    logic                stb_q, stb_d;
    logic [7:0]          dat_q, dat_d;
    logic                busy_q, busy_d;
    logic                wrap_q, wrap_d;
    logic [7:0]          tbl_q [DEPTH];
    logic [7:0]          tbl_d [DEPTH];
    logic                strobe_done;
`ifdef MENTOR_ACK_EN
    logic                err_q, err_d;
    logic                timeout;
`endif

    function automatic logic [7:0] tbl_default(int unsigned i);
        case (i)
            0:       return 8'hAA;
            1:       return 8'hF0;
            2:       return 8'hCC;
            3:       return 8'h81;
            default: return 8'h00;
        endcase
    endfunction

`ifdef MENTOR_ACK_EN
    assign timeout     = !bus.ACK_I && (stb_cnt_q == STB_LAST);
    assign strobe_done = bus.ACK_I || (stb_cnt_q == STB_LAST);
`else
    assign strobe_done = (stb_cnt_q == STB_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        stb_cnt_d = stb_cnt_q;
        stb_d     = stb_q;
        dat_d     = dat_q;
        wrap_d    = 1'b0;
        tbl_d     = tbl_q;
`ifdef MENTOR_ACK_EN
        err_d     = err_q;
`endif
        if (tbl_we_i) begin
            tbl_d[tbl_addr_i] = tbl_dat_i;
        end

        // DAT_O samples the pre-write table so a same-edge write lands on the next pass
        if (stop_i) begin
            state_d   = IDLE;
            stb_d     = 1'b0;
            idx_d     = '0;
            hold_d    = '0;
            stb_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = STROBE;
                        stb_d     = 1'b1;
                        idx_d     = '0;
                        dat_d     = tbl_q[0];
                        stb_cnt_d = '0;
`ifdef MENTOR_ACK_EN
                        err_d     = 1'b0;
`endif
                    end
                end
                STROBE: begin
                    if (strobe_done) begin
                        state_d   = HOLD;
                        stb_d     = 1'b0;
                        hold_d    = HOLD_LOAD;
                        stb_cnt_d = '0;
`ifdef MENTOR_ACK_EN
                        if (timeout) begin
                            err_d = 1'b1;
                        end
`endif
                    end else begin
                        stb_cnt_d = stb_cnt_q + SW'(1);
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d   = STROBE;
                        stb_d     = 1'b1;
                        stb_cnt_d = '0;
                        if (idx_q >= last_i) begin
                            idx_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d  = idx_q + IDX_BITS'(1);
                        end
                        dat_d = tbl_q[idx_d];
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            stb_cnt_q <= '0;
            stb_q     <= 1'b0;
            dat_q     <= 8'h00;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef MENTOR_ACK_EN
            err_q     <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= tbl_default(i);
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            stb_cnt_q <= stb_cnt_d;
            stb_q     <= stb_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            wrap_q    <= wrap_d;
`ifdef MENTOR_ACK_EN
            err_q     <= err_d;
`endif
            tbl_q     <= tbl_d;
        end
    end

    assign bus.STB_O = stb_q;
    assign bus.DAT_O = dat_q;
    assign busy_o    = busy_q;
    assign wrap_o    = wrap_q;
`ifdef MENTOR_ACK_EN
    assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_prewish_mentor.sv
// Self-checking bench for prewish_mentor: random and directed stimulus against a period/phase model.
// The MENTOR_ACK_EN build also exercises the ACK_I handshake and the timeout error.
module tb_prewish_mentor;
    localparam int IDX_BITS    = 2;
    localparam int STB_CYCLES  = 1;
    localparam int HOLD_CYCLES = 4;
    localparam int PERIOD      = STB_CYCLES + HOLD_CYCLES;
    localparam int DEPTH       = 1 << IDX_BITS;

    logic                CLK_I      = 1'b0;
    logic                RST_I      = 1'b0;
    logic                start_i    = 1'b0;
    logic                stop_i     = 1'b0;
    logic [IDX_BITS-1:0] last_i     = '0;
    logic                tbl_we_i   = 1'b0;
    logic [IDX_BITS-1:0] tbl_addr_i = '0;
    logic [7:0]          tbl_dat_i  = '0;
    logic                busy_o;
    logic                wrap_o;
`ifdef MENTOR_ACK_EN
    logic                err_o;
`endif

    prewish_mentor_if bus_if ();

    prewish_mentor #(
        .IDX_BITS    (IDX_BITS),
        .STB_CYCLES  (STB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .ACK_TIMEOUT (16)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .last_i     (last_i),
        .tbl_we_i   (tbl_we_i),
        .tbl_addr_i (tbl_addr_i),
        .tbl_dat_i  (tbl_dat_i),
        .bus        (bus_if),
        .busy_o     (busy_o),
`ifdef MENTOR_ACK_EN
        .err_o      (err_o),
`endif
        .wrap_o     (wrap_o)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int fails  = 0;

    // Reference model: a running sequence is a phase within a fixed period plus the entry index
    bit         m_run;
    int         m_phase;
    int         m_idx;
    logic [7:0] m_dat;
    bit         m_wrap;
    logic [7:0] m_tbl [DEPTH];
    logic [IDX_BITS-1:0] last_sel;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        if (obs !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_run   = 1'b0;
        m_phase = 0;
        m_idx   = 0;
        m_dat   = 8'h00;
        m_wrap  = 1'b0;
        m_tbl   = '{8'hAA, 8'hF0, 8'hCC, 8'h81};
    endtask

    task automatic modelStep();
        logic [7:0] snap [DEPTH];
        snap   = m_tbl;
        m_wrap = 1'b0;
        if (stop_i) begin
            m_run   = 1'b0;
            m_idx   = 0;
            m_phase = 0;
        end else if (!m_run) begin
            if (start_i) begin
                m_run   = 1'b1;
                m_phase = 0;
                m_idx   = 0;
                m_dat   = snap[0];
            end
        end else begin
            m_phase++;
            if (m_phase == PERIOD) begin
                m_phase = 0;
                if (m_idx >= int'(last_i)) begin
                    m_idx  = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_idx++;
                end
                m_dat = snap[m_idx];
            end
        end
        if (tbl_we_i) m_tbl[tbl_addr_i] = tbl_dat_i;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_stb"},  32'(bus_if.STB_O), 32'(m_run && (m_phase < STB_CYCLES)));
        checkOutput({tag, "_dat"},  32'(bus_if.DAT_O), 32'(m_dat));
        checkOutput({tag, "_busy"}, 32'(busy_o),       32'(m_run));
        checkOutput({tag, "_wrap"}, 32'(wrap_o),       32'(m_wrap));
`ifdef MENTOR_ACK_EN
        checkOutput({tag, "_err"},  32'(err_o),        32'(0));
`endif
    endtask

    task automatic applyStimulus(input bit st, input bit sp, input logic [IDX_BITS-1:0] lst,
                                 input bit we, input logic [IDX_BITS-1:0] ad, input logic [7:0] dt);
        start_i    = st;
        stop_i     = sp;
        last_i     = lst;
        tbl_we_i   = we;
        tbl_addr_i = ad;
        tbl_dat_i  = dt;
        @(posedge CLK_I);
        modelStep();
        #1;
        checkAll("cyc");
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, last_sel, 1'b0, '0, 8'h00);
    endtask

    task automatic waitModel(input string tag, input int idx, input int phase);
        int n;
        n = 0;
        while (!(m_run && m_idx == idx && m_phase == phase) && n < 40) begin
            idleCycles(1);
            n++;
        end
        if (n >= 40) checkOutput({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic doReset();
        RST_I = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        @(posedge CLK_I);
        @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
    endtask

`ifdef MENTOR_ACK_EN
    task automatic ackTest();
        int hi;
        int n;
        doReset();
        bus_if.ACK_I = 1'b0;
        start_i = 1'b1;
        @(posedge CLK_I);
        #1;
        start_i = 1'b0;
        hi = 0;
        while (bus_if.STB_O && hi < 40) begin
            hi++;
            if (hi == 3) bus_if.ACK_I = 1'b1;
            @(posedge CLK_I);
            #1;
            bus_if.ACK_I = 1'b0;
        end
        checkOutput("ack_len", 32'(hi), 32'(3));
        checkOutput("ack_err", 32'(err_o), 32'(0));
        n = 0;
        while (!bus_if.STB_O && n < 10) begin
            n++;
            @(posedge CLK_I);
            #1;
        end
        hi = 0;
        while (bus_if.STB_O && hi < 40) begin
            hi++;
            @(posedge CLK_I);
            #1;
        end
        checkOutput("tmo_len", 32'(hi), 32'(16));
        checkOutput("tmo_err", 32'(err_o), 32'(1));
        stop_i = 1'b1;
        @(posedge CLK_I);
        #1;
        stop_i = 1'b0;
        checkOutput("tmo_err_sticky", 32'(err_o), 32'(1));
        bus_if.ACK_I = 1'b1;
        start_i = 1'b1;
        @(posedge CLK_I);
        #1;
        start_i = 1'b0;
        checkOutput("tmo_err_clear", 32'(err_o), 32'(0));
    endtask
`endif

    initial begin
`ifdef MENTOR_ACK_EN
        bus_if.ACK_I = 1'b1;
`endif
        last_sel = 2'd3;
        doReset();

        applyStimulus(1'b1, 1'b0, last_sel, 1'b0, '0, 8'h00);
        idleCycles(24);

        waitModel("hold1", 1, 2);
        applyStimulus(1'b0, 1'b0, last_sel, 1'b1, 2'd1, 8'h3C);
        idleCycles(25);

        last_sel = 2'd0;
        idleCycles(15);

        last_sel = 2'd3;
        waitModel("hold2", 2, 2);
        applyStimulus(1'b0, 1'b1, last_sel, 1'b0, '0, 8'h00);
        applyStimulus(1'b1, 1'b1, last_sel, 1'b0, '0, 8'h00);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, last_sel, 1'b0, '0, 8'h00);
        idleCycles(10);

        for (int i = 0; i < 400; i++) begin
            if (i % 23 == 0) last_sel = IDX_BITS'($urandom_range(0, DEPTH - 1));
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0), last_sel,
                          ($urandom_range(0, 5) == 0), IDX_BITS'($urandom_range(0, DEPTH - 1)),
                          8'($urandom));
        end

        last_sel = 2'd3;
        applyStimulus(1'b1, 1'b0, last_sel, 1'b1, 2'd2, 8'h5A);
        waitModel("async", 1, 0);
        RST_I = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        applyStimulus(1'b1, 1'b0, last_sel, 1'b0, '0, 8'h00);
        idleCycles(22);

`ifdef MENTOR_ACK_EN
        ackTest();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
